// File: rtl/led_mode_ctrl_if.sv
// Button inputs and mode/enable outputs of the LED mode controller.
// master drives the raw buttons, slave is the controller itself.
interface led_mode_ctrl_if;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_pause;
    logic [1:0] mode;
    logic       enable;
    logic       mode_changed;

    modport master (
        output btn_next, btn_prev, btn_pause,
        input  mode, enable, mode_changed
    );

    modport slave (
        input  btn_next, btn_prev, btn_pause,
        output mode, enable, mode_changed
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// Push-button front end for the LED pattern generator: sync, debounce, press detect,
// mode wrap and run/pause. Optional auto-advance timer is built when AUTO_CYCLE_EN is defined.
module led_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int NUM_MODES         = 4,
    parameter int AUTO_CYCLE_CYCLES = 200000000
) (
    input  logic           clk,
    input  logic           reset,
    led_mode_ctrl_if.slave bus
);
    localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]  MAX_MODE = 2'(NUM_MODES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (NUM_MODES < 1 || NUM_MODES > 4) begin : g_bad_modes
        $error("NUM_MODES out of range");
    end
    if (AUTO_CYCLE_CYCLES < 1 || AUTO_CYCLE_CYCLES > 268435456) begin : g_bad_auto
        $error("AUTO_CYCLE_CYCLES out of range");
    end

    typedef enum logic {RUN, PAUSED} state_t;

    logic [2:0] raw;
    logic [2:0] press;
    logic       press_next;
    logic       press_prev;
    logic       press_pause;
    logic       step_next;
    logic [1:0] mode_next;

    state_t     state_reg;
    logic       enable_reg;
    logic [1:0] mode_reg;
    logic       mode_changed_reg;

    assign raw = {bus.btn_pause, bus.btn_prev, bus.btn_next};

    // Per button: 2-flop synchroniser, stability counter, one-cycle press on a debounced rise.
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic        sync1_reg;
        logic        sync2_reg;
        logic        level_reg;
        logic        press_reg;
        logic [23:0] cnt_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
                level_reg <= 1'b0;
                press_reg <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= raw[gi];
                sync2_reg <= sync1_reg;
                press_reg <= 1'b0;
                if (sync2_reg != level_reg) begin
                    if (cnt_reg == DB_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                        press_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 24'd1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end
        end

        assign press[gi] = press_reg;
    end

    assign press_next  = press[0];
    assign press_prev  = press[1];
    assign press_pause = press[2];

`ifdef AUTO_CYCLE_EN
    localparam logic [27:0] AUTO_LAST = 28'(AUTO_CYCLE_CYCLES - 1);

    logic [27:0] timer_reg;
    logic        timer_hit;
    logic        any_press;

    assign any_press = |press;
    assign timer_hit = (state_reg == RUN) && (timer_reg == AUTO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg <= '0;
        end else if (state_reg != RUN || any_press || timer_hit) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 28'd1;
        end
    end

    // A real press always beats a coincident timer step.
    assign step_next = press_next | (timer_hit & ~any_press);
`else
    assign step_next = press_next;
`endif

    always_comb begin
        mode_next = mode_reg;
        if (step_next && !press_prev) begin
            mode_next = (mode_reg == MAX_MODE) ? 2'd0 : mode_reg + 2'd1;
        end else if (press_prev && !step_next) begin
            mode_next = (mode_reg == 2'd0) ? MAX_MODE : mode_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= RUN;
            enable_reg       <= 1'b1;
            mode_reg         <= 2'd0;
            mode_changed_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (press_pause) begin
                        state_reg  <= PAUSED;
                        enable_reg <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (press_pause) begin
                        state_reg  <= RUN;
                        enable_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= RUN;
                    enable_reg <= 1'b1;
                end
            endcase
            mode_reg         <= mode_next;
            mode_changed_reg <= (mode_next != mode_reg);
        end
    end

    assign bus.mode         = mode_reg;
    assign bus.enable       = enable_reg;
    assign bus.mode_changed = mode_changed_reg;
endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
- Upstream control stage for the LED pattern generator.
- Turns three raw push-buttons (next, prev, pause) into a clean 2-bit pattern mode and a run/pause enable.
- Handles synchronisation, debouncing, press-edge detection, mode wrap-around and run/pause state.
- Drives the generator's mode and enable inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed before a debounced button changes state (5 ms at 100 MHz); legal range 2..2^24-1.
- NUM_MODES, 4, number of legal modes (1..4); mode cycles over 0..NUM_MODES-1.
- AUTO_CYCLE_CYCLES, 200000000, auto-advance period in cycles; used only when AUTO_CYCLE_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_next  in  1  raw asynchronous button; a press advances the mode.
- btn_prev  in  1  raw asynchronous button; a press steps the mode back.
- btn_pause  in  1  raw asynchronous button; a press toggles run/pause.
- mode  out  2  current pattern mode, registered.
- enable  out  1  high in RUN, low in PAUSED, registered.
- mode_changed  out  1  one-cycle pulse in the cycle `mode` takes a new value.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - mode=0, enable=1 (state RUN), mode_changed=0.
  - All synchroniser flops, debounced levels, debounce counters and press flags at 0.
- Synchroniser: each button passes through a 2-flop synchroniser before any other use.
- Debounce, per button:
  - 24-bit counter compares the synchronised level with the debounced level.
  - On mismatch the counter increments; on match it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the debounced level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Press detect:
  - A registered press pulse is asserted for exactly one cycle after a debounced 0->1 edge.
  - Release (1->0) produces no pulse.
  - Holding a button produces exactly one pulse.
- Latency: clean raw rising edge to `mode` update = DEBOUNCE_CYCLES+3 clk edges; bench tolerance ±1 for asynchronous sampling.
- State machine, two states:
  - RUN (enable=1): pause press -> PAUSED.
  - PAUSED (enable=0): pause press -> RUN.
  - enable is registered and changes in the same edge as the state.
- Mode update, evaluated every cycle from the press pulses:
  - next only: mode = (mode==NUM_MODES-1) ? 0 : mode+1.
  - prev only: mode = (mode==0) ? NUM_MODES-1 : mode-1.
  - next and prev in the same cycle: no change, no mode_changed pulse.
  - Mode changes are accepted in both RUN and PAUSED; enable is unaffected.
  - Pause press coinciding with next or prev: both actions take effect in the same edge.
- mode_changed:
  - High for one cycle whenever the registered mode differs from its previous value.
  - With NUM_MODES=1, mode stays 0 and mode_changed never asserts.
- Reset asserted mid-debounce or mid-press: all in-flight counts are discarded.
  - A button still held at reset release must be seen as a new press only after a full debounce window.
- Width rules:
  - mode is fixed at 2 bits.
  - Counters saturate-free: they clear before overflow by construction of the DEBOUNCE_CYCLES range.

Optional Feature:
- Macro AUTO_CYCLE_EN.
- Defined:
  - A 28-bit auto timer runs only in RUN.
  - At count AUTO_CYCLE_CYCLES-1 it applies a "next" step (same wrap rule, pulses mode_changed) and clears.
  - Any next, prev or pause press clears the timer.
  - In PAUSED the timer is held at 0.
  - A timer step coinciding with a prev press: the press wins and the timer clears.
- Not defined: no timer logic is synthesised; mode changes only on button presses; AUTO_CYCLE_CYCLES is ignored.

Test Plan (DEBOUNCE_CYCLES=4, NUM_MODES=4, AUTO_CYCLE_CYCLES=20):
- Reset check: assert reset mid-cycle -> mode=0, enable=1 and mode_changed=0 immediately; hold btn_next through reset release -> no mode change until 4+3 edges after release.
- Debounce: btn_next 3-cycle glitch -> mode stays 0; btn_next held 10 cycles -> mode=1 at edge 7 (±1) with one mode_changed pulse; held 1000 cycles -> still exactly one step.
- Wrap: four next presses from 0 -> 1,2,3,0; prev press from 0 -> 3.
- Simultaneous: next and prev rising on the same cycle -> mode unchanged, no mode_changed pulse.
- Pause: pause press -> enable=0; next press -> mode advances while enable stays 0; second pause press -> enable=1.
- With AUTO_CYCLE_EN: idle in RUN -> mode steps every 20 cycles; PAUSED for 100 cycles -> no step; next press at count 15 -> timer restarts from 0.
